hash_engine: RTL and testbench
==============================

# hash_engine

Sequential, parametrised multi-round byte hash core. Accepts a byte stream over a valid/ready handshake and applies NUM_ROUNDS mixing rounds per byte, one round per clock, to a 4-lane chaining state. After the byte flagged last, it presents the digest until the consumer takes it. It is the streaming successor to the single-stage combinational round and sits between the byte source and the digest compare/display logic.

## Interface
- LANE_W, 8: lane width in bits; state/digest width is 4*LANE_W; input symbol width is LANE_W.
- NUM_ROUNDS, 5: rounds applied per input symbol; legal range is 1 or more.
- IV, 0: 4*LANE_W-bit initial chaining state, packed {d,c,b,a} with a in the LSBs.
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_byte/in_last are valid.
- in_ready, output, 1: engine can accept a symbol.
- in_byte, input, LANE_W: message symbol.
- in_last, input, 1: this symbol ends the message.
- out_valid, output, 1: digest is valid.
- out_ready, input, 1: consumer accepts the digest.
- digest, output, 4*LANE_W: current chaining state; meaningful while out_valid=1.
- busy, output, 1: high in ROUND or DONE.

## Operation
- Registers: state (4*LANE_W), byte_q (LANE_W), last_q, round counter r (width clog2(NUM_ROUNDS+1)), FSM.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch byte_q<=in_byte and last_q<=in_last, set r<=1, go to ROUND.
  - ROUND: in_ready=0. Each cycle, state<=round(state, byte_q, r) and r<=r+1. On the edge that applies r==NUM_ROUNDS, go to DONE if last_q, else IDLE.
  - DONE: out_valid=1. On out_valid&out_ready, state<=IV, go to IDLE.
- Round function: split {d,c,b,a}=state.
  - mix for r<=2: (c&b)|(~b&d). Rounds r=0..2 use this select rule; r=0 is never issued.
  - mix for r=3 or 4: (c&b)|(b&d)|(c&d).
  - mix for r>=5: c^b^d.
  - t = mix + a + byte_q, modulo 2^LANE_W with carries discarded.
  - a' = t rotated left by (r mod LANE_W).
  - new state = {c, b, a', d}.
- The same byte_q is used for every round of that symbol.
- digest is driven directly from state.
- in_valid while in_ready=0 is ignored. The source must hold its data, but the engine reads it only at acceptance.
- An empty message is not supported. Every message ends with a symbol carrying in_last=1.

## Timing
- Reset values: state=IV, FSM=IDLE, r=0, byte_q=0, last_q=0. Outputs after reset: in_ready=1, out_valid=0, busy=0, digest=IV.
- Reset asserted at any point (mid-ROUND or in DONE) aborts immediately: same values as above. No partial digest is emitted.
- Accept edge is T. Round r is applied at edge T+r.
- Non-last symbol: in_ready returns to 1 in the cycle after edge T+NUM_ROUNDS. Throughput is one symbol per NUM_ROUNDS+1 cycles.
- Last symbol: out_valid rises in the cycle after edge T+NUM_ROUNDS and holds, with digest stable, until a cycle with out_ready=1.
- out_ready already high when DONE is entered: digest is consumed at the first DONE edge, so out_valid is high for exactly 1 cycle. The next cycle is IDLE with state=IV.
- in_ready and out_valid are never both 1.

## Test plan
- LANE_W=8, NUM_ROUNDS=1, IV=0; send 0x01 with last=1 -> one cycle later out_valid=1, digest=0x00000200. Hold out_ready=0 for 5 cycles -> digest stable. Then out_ready=1 -> IDLE, digest=0.
- NUM_ROUNDS=1, IV=0x04030201; send 0x10 with last=1 -> digest=0x03022E04.
- NUM_ROUNDS=2, IV=0; send 0x01 with last=1 -> after round 1, state=0x00000200; after round 2, digest=0x00020400. in_ready is low for exactly 2 cycles.
- NUM_ROUNDS=5, IV=0; stream 3 symbols with in_valid held high:
  - in_ready pulses once every 6 cycles.
  - Symbols presented while in_ready=0 are not consumed.
  - digest matches the reference model, covering all three mix functions.
- Assert reset for 1 cycle during round 3 of a last symbol -> state=IV, in_ready=1, out_valid never rises. A fresh message then produces the same digest as a run without the abort.
- LANE_W=4, NUM_ROUNDS=6 -> round 4 uses rotation 0 and round 6 uses rotation 2, and sums wrap modulo 16. Digest matches the model.

Source files
------------

// File: rtl/hash_engine.sv
// Streaming multi-round byte hash: each accepted symbol is mixed into a 4-lane
// chaining state over NUM_ROUNDS clocks; the state is presented as the digest after the last symbol.
module hash_engine #(
    parameter int                  LANE_W     = 8,
    parameter int                  NUM_ROUNDS = 5,
    parameter logic [4*LANE_W-1:0] IV         = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_W-1:0]     in_byte,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*LANE_W-1:0]   digest,
    output logic                  busy
);

    localparam int RW = $clog2(NUM_ROUNDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    fsm_t                r_fsm;
    logic [4*LANE_W-1:0] r_state;
    logic [LANE_W-1:0]   r_byte;
    logic                r_last;
    logic [RW-1:0]       r_r;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    // One mixing round; the boolean mix changes with the round index.
    function automatic logic [4*LANE_W-1:0] round_fn(
        input logic [4*LANE_W-1:0] st,
        input logic [LANE_W-1:0]   sym,
        input logic [RW-1:0]       rnd
    );
        logic [LANE_W-1:0] a, b, c, d, mix, t, a_rot;
        int                ri;
        int                rot;
        {d, c, b, a} = st;
        ri = int'(rnd);
        if (ri <= 2)
            mix = (c & b) | (~b & d);
        else if (ri <= 4)
            mix = (c & b) | (b & d) | (c & d);
        else
            mix = c ^ b ^ d;
        t     = mix + a + sym;
        rot   = ri % LANE_W;
        a_rot = (t << rot) | (t >> (LANE_W - rot));
        return {c, b, a_rot, d};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= S_IDLE;
            r_state     <= IV;
            r_byte      <= '0;
            r_last      <= 1'b0;
            r_r         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_byte     <= in_byte;
                        r_last     <= in_last;
                        r_r        <= RW'(1);
                        r_fsm      <= S_ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_state <= round_fn(r_state, r_byte, r_r);
                    r_r     <= r_r + RW'(1);
                    if (r_r == RW'(NUM_ROUNDS)) begin
                        if (r_last) begin
                            r_fsm       <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_fsm      <= S_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    // Digest is held until the consumer takes it, then the chain restarts.
                    if (out_ready) begin
                        r_state     <= IV;
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign digest    = r_state;

endmodule

// File: tb/tb_hash_engine.sv
// Bench for hash_engine: several parameterisations checked against a lane-level
// reference model, with table vectors, random messages and hand-written corner sequences.
module tb_hash_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_vec = 0;
    int n_bad = 0;

    typedef logic [7:0] msg_t [8];

    typedef struct {
        msg_t        m;
        int          len;
        bit          early;
        logic [31:0] exp;
    } vec_t;

    // A: LANE_W=8, NUM_ROUNDS=5, IV=0
    logic a_valid, a_ready, a_last, a_ovalid, a_oready, a_busy;
    logic [7:0]  a_byte;
    logic [31:0] a_digest;
    hash_engine #(.LANE_W(8), .NUM_ROUNDS(5), .IV(32'h0)) u_a (
        .clk(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_ready), .in_byte(a_byte),
        .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready), .digest(a_digest), .busy(a_busy));

    // B: NUM_ROUNDS=1, IV=0 ; C: NUM_ROUNDS=1, IV=0x04030201 (shares handshake with B)
    logic b_valid, b_ready, b_last, b_ovalid, b_oready, b_busy;
    logic [7:0]  b_byte;
    logic [31:0] b_digest;
    hash_engine #(.LANE_W(8), .NUM_ROUNDS(1), .IV(32'h0)) u_b (
        .clk(clk), .reset(rst), .in_valid(b_valid), .in_ready(b_ready), .in_byte(b_byte),
        .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready), .digest(b_digest), .busy(b_busy));

    logic c_ready, c_ovalid, c_busy;
    logic [7:0]  c_byte;
    logic [31:0] c_digest;
    hash_engine #(.LANE_W(8), .NUM_ROUNDS(1), .IV(32'h04030201)) u_c (
        .clk(clk), .reset(rst), .in_valid(b_valid), .in_ready(c_ready), .in_byte(c_byte),
        .in_last(b_last), .out_valid(c_ovalid), .out_ready(b_oready), .digest(c_digest), .busy(c_busy));

    // D: NUM_ROUNDS=2, IV=0
    logic d_valid, d_ready, d_last, d_ovalid, d_oready, d_busy;
    logic [7:0]  d_byte;
    logic [31:0] d_digest;
    hash_engine #(.LANE_W(8), .NUM_ROUNDS(2), .IV(32'h0)) u_d (
        .clk(clk), .reset(rst), .in_valid(d_valid), .in_ready(d_ready), .in_byte(d_byte),
        .in_last(d_last), .out_valid(d_ovalid), .out_ready(d_oready), .digest(d_digest), .busy(d_busy));

    // E: LANE_W=4, NUM_ROUNDS=6
    localparam logic [15:0] E_IV = 16'hA5C3;
    logic e_valid, e_ready, e_last, e_ovalid, e_oready, e_busy;
    logic [3:0]  e_byte;
    logic [15:0] e_digest;
    hash_engine #(.LANE_W(4), .NUM_ROUNDS(6), .IV(E_IV)) u_e (
        .clk(clk), .reset(rst), .in_valid(e_valid), .in_ready(e_ready), .in_byte(e_byte),
        .in_last(e_last), .out_valid(e_ovalid), .out_ready(e_oready), .digest(e_digest), .busy(e_busy));

    // Reference: four integer lanes, mix evaluated bit by bit from its truth rule.
    function automatic logic [31:0] ref_hash(input int lw, input int nr, input logic [31:0] iv,
                                             input msg_t m, input int len);
        int unsigned l[4];
        int unsigned mask, mix, t, rot, sym, na, bb, cc, dd, o;
        mask = (32'd1 << lw) - 1;
        for (int k = 0; k < 4; k++) l[k] = (iv >> (k * lw)) & mask;
        for (int s = 0; s < len; s++) begin
            sym = {24'd0, m[s]} & mask;
            for (int r = 1; r <= nr; r++) begin
                mix = 0;
                for (int i = 0; i < lw; i++) begin
                    bb = (l[1] >> i) & 1;
                    cc = (l[2] >> i) & 1;
                    dd = (l[3] >> i) & 1;
                    if (r <= 2)      o = (bb != 0) ? cc : dd;
                    else if (r <= 4) o = ((bb + cc + dd) >= 2) ? 1 : 0;
                    else             o = (bb + cc + dd) % 2;
                    mix = mix | (o << i);
                end
                t   = (mix + l[0] + sym) % (32'd1 << lw);
                rot = r % lw;
                t   = ((t << rot) | (t >> (lw - rot))) & mask;
                na   = l[3];
                l[3] = l[2];
                l[2] = l[1];
                l[1] = t;
                l[0] = na;
            end
        end
        return l[0] | (l[1] << lw) | (l[2] << (2 * lw)) | (l[3] << (3 * lw));
    endfunction

    function automatic msg_t mk4(input logic [7:0] x0, input logic [7:0] x1,
                                 input logic [7:0] x2, input logic [7:0] x3);
        msg_t m = '{default: 8'h00};
        m[0] = x0; m[1] = x1; m[2] = x2; m[3] = x3;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Sends a message to A with in_valid held high; bytes shown while not ready are junk.
    task automatic send_a(input msg_t m, input int len, input bit early, output logic [31:0] dig);
        int w;
        for (int s = 0; s < len; s++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_last  = (s == len - 1);
            a_byte  = m[s];
            w = 0;
            while (!a_ready && w < 50) begin
                a_byte = 8'($urandom);
                @(negedge clk);
                w++;
            end
            a_byte = m[s];
            if (w >= 50) chk("a_accept_timeout", 32'(w), 32'd0);
            else if (s > 0) chk("a_ready_gap", 32'(w), 32'd5);
            @(posedge clk);
        end
        @(negedge clk);
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_byte  = 8'h00;
        if (early) a_oready = 1'b1;
        w = 0;
        while (!a_ovalid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("a_done_latency", 32'(w), 32'd5);
        chk("a_ready_in_done", {31'd0, a_ready}, 32'd0);
        dig = a_digest;
        a_oready = 1'b1;
        @(negedge clk);
        chk("a_ovalid_after_take", {31'd0, a_ovalid}, 32'd0);
        chk("a_ready_after_take", {31'd0, a_ready}, 32'd1);
        chk("a_digest_iv", a_digest, 32'h0);
        a_oready = 1'b0;
    endtask

    task automatic send_e(input msg_t m, input int len, output logic [15:0] dig);
        int w;
        for (int s = 0; s < len; s++) begin
            @(negedge clk);
            e_valid = 1'b1;
            e_last  = (s == len - 1);
            e_byte  = m[s][3:0];
            w = 0;
            while (!e_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) chk("e_accept_timeout", 32'(w), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        e_valid = 1'b0;
        e_last  = 1'b0;
        w = 0;
        while (!e_ovalid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("e_done_latency", 32'(w), 32'd6);
        dig = e_digest;
        e_oready = 1'b1;
        @(negedge clk);
        chk("e_digest_iv", {16'd0, e_digest}, {16'd0, E_IV});
        e_oready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [31:0] dig;
        logic [15:0] edig;
        msg_t        rm;
        int          rl;
        int          w;
        bit          rose;

        rst = 1'b1;
        a_valid = 0; a_last = 0; a_byte = 0; a_oready = 0;
        b_valid = 0; b_last = 0; b_byte = 0; b_oready = 0; c_byte = 0;
        d_valid = 0; d_last = 0; d_byte = 0; d_oready = 0;
        e_valid = 0; e_last = 0; e_byte = 0; e_oready = 0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_a_ovalid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_digest", a_digest, 32'h0);
        chk("rst_c_digest", c_digest, 32'h04030201);
        chk("rst_e_digest", {16'd0, e_digest}, {16'd0, E_IV});
        rst = 1'b0;

        // NUM_ROUNDS=1 single symbol, held digest, then release
        @(negedge clk);
        b_valid = 1; b_last = 1; b_byte = 8'h01; c_byte = 8'h10;
        @(posedge clk);
        @(negedge clk);
        b_valid = 0; b_last = 0;
        chk("b_busy_round", {31'd0, b_busy}, 32'd1);
        chk("b_ready_round", {31'd0, b_ready}, 32'd0);
        chk("b_ovalid_round", {31'd0, b_ovalid}, 32'd0);
        @(negedge clk);
        chk("b_ovalid", {31'd0, b_ovalid}, 32'd1);
        chk("b_digest", b_digest, 32'h00000200);
        chk("c_digest", c_digest, 32'h03022E04);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_hold_ovalid", {31'd0, b_ovalid}, 32'd1);
            chk("b_hold_digest", b_digest, 32'h00000200);
        end
        b_oready = 1;
        @(negedge clk);
        chk("b_take_ovalid", {31'd0, b_ovalid}, 32'd0);
        chk("b_take_ready", {31'd0, b_ready}, 32'd1);
        chk("b_take_digest", b_digest, 32'h0);
        chk("c_take_digest", c_digest, 32'h04030201);
        b_oready = 0;

        // NUM_ROUNDS=2: per-round state, then a non-last gap
        @(negedge clk);
        d_valid = 1; d_last = 1; d_byte = 8'h01;
        @(posedge clk);
        @(negedge clk);
        d_valid = 0;
        chk("d_r0_digest", d_digest, 32'h0);
        chk("d_r0_ready", {31'd0, d_ready}, 32'd0);
        @(negedge clk);
        chk("d_r1_digest", d_digest, 32'h00000200);
        chk("d_r1_ovalid", {31'd0, d_ovalid}, 32'd0);
        @(negedge clk);
        chk("d_r2_digest", d_digest, 32'h00020400);
        chk("d_r2_ovalid", {31'd0, d_ovalid}, 32'd1);
        d_oready = 1;
        @(negedge clk);
        chk("d_take_ready", {31'd0, d_ready}, 32'd1);
        d_oready = 0;
        d_valid = 1; d_last = 0; d_byte = 8'h01;
        @(posedge clk);
        @(negedge clk);
        d_valid = 0;
        w = 0;
        while (!d_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("d_ready_low_cycles", 32'(w), 32'd2);
        d_valid = 1; d_last = 1; d_byte = 8'h00;
        @(posedge clk);
        @(negedge clk);
        d_valid = 0; d_last = 0;
        w = 0;
        while (!d_ovalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("d_two_sym_digest", d_digest, ref_hash(8, 2, 32'h0, mk4(8'h01, 8'h00, 8'h00, 8'h00), 2));
        d_oready = 1;
        @(negedge clk);
        d_oready = 0;

        // Table vectors on the NUM_ROUNDS=5 engine
        tbl[0] = '{m: mk4(8'h01, 8'h00, 8'h00, 8'h00), len: 1, early: 1'b0, exp: 32'h0};
        tbl[1] = '{m: mk4(8'h00, 8'hFF, 8'h80, 8'h00), len: 3, early: 1'b0, exp: 32'h0};
        tbl[2] = '{m: mk4(8'hDE, 8'hAD, 8'hBE, 8'hEF), len: 4, early: 1'b0, exp: 32'h0};
        tbl[3] = '{m: mk4(8'h55, 8'h00, 8'h00, 8'h00), len: 1, early: 1'b1, exp: 32'h0};
        tbl[4] = '{m: mk4(8'hA7, 8'h3C, 8'hF1, 8'h00), len: 3, early: 1'b1, exp: 32'h0};
        for (int i = 0; i < 5; i++) tbl[i].exp = ref_hash(8, 5, 32'h0, tbl[i].m, tbl[i].len);
        for (int i = 0; i < 5; i++) begin
            send_a(tbl[i].m, tbl[i].len, tbl[i].early, dig);
            chk($sformatf("a_tbl%0d_digest", i), dig, tbl[i].exp);
        end

        // Random messages on A
        for (int n = 0; n < 6; n++) begin
            rl = $urandom_range(1, 8);
            for (int k = 0; k < 8; k++) rm[k] = 8'($urandom);
            send_a(rm, rl, n[0], dig);
            chk($sformatf("a_rand%0d_digest", n), dig, ref_hash(8, 5, 32'h0, rm, rl));
        end

        // Abort during round 3 of a last symbol
        @(negedge clk);
        a_valid = 1; a_last = 1; a_byte = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0; a_last = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_digest", a_digest, 32'h0);
        chk("abort_ready", {31'd0, a_ready}, 32'd1);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ovalid) rose = 1'b1;
        end
        chk("abort_no_ovalid", {31'd0, rose}, 32'd0);
        send_a(mk4(8'h5A, 8'h00, 8'h00, 8'h00), 1, 1'b0, dig);
        chk("abort_rerun_digest", dig, ref_hash(8, 5, 32'h0, mk4(8'h5A, 8'h00, 8'h00, 8'h00), 1));

        // LANE_W=4, NUM_ROUNDS=6
        send_e(mk4(8'h0F, 8'h00, 8'h00, 8'h00), 1, edig);
        chk("e_fixed_digest", {16'd0, edig}, ref_hash(4, 6, {16'd0, E_IV}, mk4(8'h0F, 8'h00, 8'h00, 8'h00), 1));
        for (int n = 0; n < 5; n++) begin
            rl = $urandom_range(1, 6);
            for (int k = 0; k < 8; k++) rm[k] = {4'h0, 4'($urandom)};
            send_e(rm, rl, edig);
            chk($sformatf("e_rand%0d_digest", n), {16'd0, edig}, ref_hash(4, 6, {16'd0, E_IV}, rm, rl));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
